shot_clock_timer: RTL and testbench

Parametrised two-digit countdown shot clock driving two 9-bit seven-segment patterns. It succeeds the fixed 24 s free-running timer with:
- configurable start value, alternate reload value and tick divider;
- run/pause control, expiry pulse and timed buzzer;
- optional auto-restart.

It sits between the board's push-button conditioning logic and the two-digit common-cathode display.

---
 rtl/shot_clock_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 14 +
 rtl/shot_clock_timer.sv | 188 ++++++++++++++++++
 tb/tb_shot_clock_timer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shot_clock_pkg.sv
// Shared definitions for the shot clock: controller states and the
// seven-segment patterns for a common-cathode digit ([6:0] = g..a).
package shot_clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [8:0] SEG_BLANK = 9'h000;

    localparam logic [8:0] SEG_0 = 9'h03f;
    localparam logic [8:0] SEG_1 = 9'h006;
    localparam logic [8:0] SEG_2 = 9'h05b;
    localparam logic [8:0] SEG_3 = 9'h04f;
    localparam logic [8:0] SEG_4 = 9'h066;
    localparam logic [8:0] SEG_5 = 9'h06d;
    localparam logic [8:0] SEG_6 = 9'h07d;
    localparam logic [8:0] SEG_7 = 9'h007;
    localparam logic [8:0] SEG_8 = 9'h07f;
    localparam logic [8:0] SEG_9 = 9'h06f;

    // Non-BCD codes blank the digit rather than show garbage.
    function automatic logic [8:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_pattern = SEG_0;
            4'd1:    seg_pattern = SEG_1;
            4'd2:    seg_pattern = SEG_2;
            4'd3:    seg_pattern = SEG_3;
            4'd4:    seg_pattern = SEG_4;
            4'd5:    seg_pattern = SEG_5;
            4'd6:    seg_pattern = SEG_6;
            4'd7:    seg_pattern = SEG_7;
            4'd8:    seg_pattern = SEG_8;
            4'd9:    seg_pattern = SEG_9;
            default: seg_pattern = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 9-bit seven-segment pattern, purely combinational.
module seg7_decode
    import shot_clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [8:0] seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        seg = seg_pattern(bcd);
    end

endmodule

// File: rtl/shot_clock_timer.sv
// Two-digit BCD countdown shot clock with run/pause, two reload values,
// expiry pulse, timed buzzer and optional auto-restart.
// Optional build macro SHOT_CLOCK_BLINK_EN: flash the 00 display while expired.
module shot_clock_timer
    import shot_clock_pkg::*;
#(
    parameter int CLK_DIV     = 12_000_000,
    parameter int START_VAL   = 24,
    parameter int ALT_VAL     = 14,
    parameter int BUZZ_TICKS  = 2,
    parameter int AUTO_RELOAD = 0
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       StartPause,
    input  logic       Reload,
    input  logic       ReloadAlt,
    output logic [8:0] Seg1,
    output logic [8:0] Seg2,
    output logic       Expire,
    output logic       Buzz
);

    localparam int PRESC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BUZZ_W  = $clog2(BUZZ_TICKS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_LOAD  = BUZZ_W'(BUZZ_TICKS);
    localparam logic [3:0] START_TENS = 4'(START_VAL / 10);
    localparam logic [3:0] START_ONES = 4'(START_VAL % 10);
    localparam logic [3:0] ALT_TENS   = 4'(ALT_VAL / 10);
    localparam logic [3:0] ALT_ONES   = 4'(ALT_VAL % 10);

    state_t              state_reg, state_next;
    logic [3:0]          tens_reg, tens_next;
    logic [3:0]          ones_reg, ones_next;
    logic [PRESC_W-1:0]  presc_reg, presc_next;
    logic [BUZZ_W-1:0]   buzz_cnt_reg, buzz_cnt_next;
    logic                buzz_reg, buzz_next;
    logic                expire_reg, expire_next;
    logic                presc_wrap;
    logic [PRESC_W-1:0]  presc_inc;
    logic                blank_now;
    logic [3:0]          digit_bcd [2];
    logic [8:0]          digit_seg [2];

    assign presc_wrap = (presc_reg == PRESC_LAST);
    assign presc_inc  = presc_wrap ? '0 : presc_reg + 1'b1;

`ifdef SHOT_CLOCK_BLINK_EN
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_DIV / 2);
    assign blank_now = (state_reg == EXPIRED) && (presc_reg >= PRESC_HALF);
`else
    assign blank_now = 1'b0;
`endif

    // Controller: reloads win over run/pause; ticks decrement the BCD count
    always_comb begin
        state_next    = state_reg;
        tens_next     = tens_reg;
        ones_next     = ones_reg;
        presc_next    = presc_reg;
        buzz_next     = buzz_reg;
        buzz_cnt_next = buzz_cnt_reg;
        expire_next   = 1'b0;

        if (Reload || ReloadAlt) begin
            tens_next     = Reload ? START_TENS : ALT_TENS;
            ones_next     = Reload ? START_ONES : ALT_ONES;
            presc_next    = '0;
            buzz_next     = 1'b0;
            buzz_cnt_next = '0;
            state_next    = (state_reg == RUN) ? RUN : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (StartPause) begin
                        state_next = RUN;
                        presc_next = '0;
                    end
                end
                PAUSE: begin
                    // prescaler keeps its frozen value so the second is resumed
                    if (StartPause) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (StartPause) begin
                        state_next = PAUSE;
                    end else begin
                        presc_next = presc_inc;
                        if (presc_wrap) begin
                            if (tens_reg == 4'd0 && ones_reg == 4'd1) begin
                                ones_next     = 4'd0;
                                state_next    = EXPIRED;
                                expire_next   = 1'b1;
                                buzz_next     = 1'b1;
                                buzz_cnt_next = BUZZ_LOAD;
                            end else if (ones_reg != 4'd0) begin
                                ones_next = ones_reg - 4'd1;
                            end else if (tens_reg != 4'd0) begin
                                ones_next = 4'd9;
                                tens_next = tens_reg - 4'd1;
                            end
                        end
                    end
                end
                EXPIRED: begin
                    // prescaler free-runs here to time the buzzer (and blink)
                    presc_next = presc_inc;
                    if (presc_wrap && buzz_reg) begin
                        if (buzz_cnt_reg == BUZZ_W'(1)) begin
                            buzz_next     = 1'b0;
                            buzz_cnt_next = '0;
                            if (AUTO_RELOAD != 0) begin
                                state_next = RUN;
                                tens_next  = START_TENS;
                                ones_next  = START_ONES;
                                presc_next = '0;
                            end
                        end else begin
                            buzz_cnt_next = buzz_cnt_reg - BUZZ_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            tens_reg     <= START_TENS;
            ones_reg     <= START_ONES;
            presc_reg    <= '0;
            buzz_cnt_reg <= '0;
            buzz_reg     <= 1'b0;
            expire_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tens_reg     <= tens_next;
            ones_reg     <= ones_next;
            presc_reg    <= presc_next;
            buzz_cnt_reg <= buzz_cnt_next;
            buzz_reg     <= buzz_next;
            expire_reg   <= expire_next;
        end
    end

    assign digit_bcd[0] = tens_reg;
    assign digit_bcd[1] = ones_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            localparam logic [3:0] RESET_DIGIT = (gi == 0) ? START_TENS : START_ONES;
            logic [8:0] seg_reg, seg_next;

            seg7_decode u_decode (
                .bcd (digit_bcd[gi]),
                .seg (digit_seg[gi])
            );

            // Pattern shown next cycle, blanked during the dark half of a blink
            always_comb begin
                seg_next = blank_now ? SEG_BLANK : digit_seg[gi];
            end

            // Display register, one cycle behind the count
            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    seg_reg <= seg_pattern(RESET_DIGIT);
                end else begin
                    seg_reg <= seg_next;
                end
            end
        end
    endgenerate

    assign Seg1   = g_digit[0].seg_reg;
    assign Seg2   = g_digit[1].seg_reg;
    assign Expire = expire_reg;
    assign Buzz   = buzz_reg;

endmodule

// File: tb/tb_shot_clock_timer.sv
// Scoreboard bench for shot_clock_timer: stimulus pushes expected display,
// Expire and Buzz values tagged with a cycle number; a monitor on the falling
// edge pops each entry when its cycle arrives and compares.
// dut_a uses AUTO_RELOAD=0, dut_b uses AUTO_RELOAD=1; both CLK_DIV=4.
module tb_shot_clock_timer;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       sp_a, rl_a, ra_a, sp_b, rl_b, ra_b;
    logic [8:0] seg1_a, seg2_a, seg1_b, seg2_b;
    logic       expire_a, buzz_a, expire_b, buzz_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit finishing = 1'b0;

    typedef struct packed {
        int          at;
        logic        dut;
        logic [8:0]  s1;
        logic [8:0]  s2;
        logic        ex;
        logic        bz;
        logic [95:0] nm;
    } exp_t;

    exp_t sb_q [$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    shot_clock_timer #(
        .CLK_DIV(4), .START_VAL(24), .ALT_VAL(14), .BUZZ_TICKS(2), .AUTO_RELOAD(0)
    ) dut_a (
        .CLK(CLK), .Reset(Reset), .StartPause(sp_a), .Reload(rl_a), .ReloadAlt(ra_a),
        .Seg1(seg1_a), .Seg2(seg2_a), .Expire(expire_a), .Buzz(buzz_a)
    );

    shot_clock_timer #(
        .CLK_DIV(4), .START_VAL(24), .ALT_VAL(14), .BUZZ_TICKS(2), .AUTO_RELOAD(1)
    ) dut_b (
        .CLK(CLK), .Reset(Reset), .StartPause(sp_b), .Reload(rl_b), .ReloadAlt(ra_b),
        .Seg1(seg1_b), .Seg2(seg2_b), .Expire(expire_b), .Buzz(buzz_b)
    );

    function automatic logic [8:0] seg_of(input int d);
        case (d)
            0: return 9'h03f;
            1: return 9'h006;
            2: return 9'h05b;
            3: return 9'h04f;
            4: return 9'h066;
            5: return 9'h06d;
            6: return 9'h07d;
            7: return 9'h007;
            8: return 9'h07f;
            9: return 9'h06f;
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [17:0] disp(input int n);
        return {seg_of(n / 10), seg_of(n % 10)};
    endfunction

    task automatic expect_at(input int at, input logic dut, input int n,
                             input logic ex, input logic bz, input logic [95:0] nm);
        exp_t       item;
        logic [17:0] d;
        d       = disp(n);
        item.at  = at;
        item.dut = dut;
        item.s1  = d[17:9];
        item.s2  = d[8:0];
        item.ex  = ex;
        item.bz  = bz;
        item.nm  = nm;
        sb_q.push_back(item);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // mask bits: {ra_b, rl_b, sp_b, ra_a, rl_a, sp_a}; returns the sampling edge
    task automatic pulse(input logic [5:0] m, output int at);
        {ra_b, rl_b, sp_b, ra_a, rl_a, sp_a} = m;
        step();
        {ra_b, rl_b, sp_b, ra_a, rl_a, sp_a} = 6'b0;
        at = cyc;
    endtask

    // Monitor: compare every expectation whose cycle has come
    exp_t       cur;
    logic [8:0] a1, a2;
    logic       ae, ab;
    always @(negedge CLK) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            cur = sb_q.pop_front();
            if (cur.dut) begin
                a1 = seg1_b; a2 = seg2_b; ae = expire_b; ab = buzz_b;
            end else begin
                a1 = seg1_a; a2 = seg2_a; ae = expire_a; ab = buzz_a;
            end
            checks++;
            if (cur.at != cyc || a1 !== cur.s1 || a2 !== cur.s2 || ae !== cur.ex || ab !== cur.bz) begin
                errors++;
                $display("FAIL %0s dut=%0d cyc=%0d(due %0d) got seg1=%h seg2=%h expire=%b buzz=%b want seg1=%h seg2=%h expire=%b buzz=%b",
                         cur.nm, cur.dut, cyc, cur.at, a1, a2, ae, ab, cur.s1, cur.s2, cur.ex, cur.bz);
            end else begin
                $display("ok   %0s dut=%0d cyc=%0d seg1=%h seg2=%h expire=%b buzz=%b",
                         cur.nm, cur.dut, cyc, a1, a2, ae, ab);
            end
        end
        if (finishing) begin
            finishing = 1'b0;
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d pending entries want 0", sb_q.size());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, p, r, l, s, t, u, v, q;
        Reset = 1'b1;
        {ra_b, rl_b, sp_b, ra_a, rl_a, sp_a} = 6'b0;
        repeat (3) step();
        Reset = 1'b0;

        // reset state and no movement while idle
        for (int i = 1; i <= 20; i++) expect_at(cyc + i, 1'b0, 24, 1'b0, 1'b0, "idle_hold");
        expect_at(cyc + 20, 1'b1, 24, 1'b0, 1'b0, "b_idle");
        wait_until(cyc + 20);

        // start: first tick CLK_DIV cycles after the pulse, display one later
        pulse(6'b000001, e);
        expect_at(e + 4, 1'b0, 24, 1'b0, 1'b0, "pre_tick");
        expect_at(e + 5, 1'b0, 23, 1'b0, 1'b0, "first_tick");
        // BCD borrow 10 -> 09
        expect_at(e + 57, 1'b0, 10, 1'b0, 1'b0, "at_10");
        expect_at(e + 60, 1'b0, 10, 1'b0, 1'b0, "pre_borrow");
        expect_at(e + 61, 1'b0, 9, 1'b0, 1'b0, "borrow");

        // pause with prescaler at 2, hold 50 cycles, resume
        wait_until(e + 62);
        pulse(6'b000001, p);
        expect_at(p + 1, 1'b0, 9, 1'b0, 1'b0, "pause_entry");
        expect_at(p + 25, 1'b0, 9, 1'b0, 1'b0, "pause_hold");
        wait_until(p + 50);
        pulse(6'b000001, r);
        expect_at(r, 1'b0, 9, 1'b0, 1'b0, "resume");
        expect_at(r + 2, 1'b0, 9, 1'b0, 1'b0, "resume_pre");
        expect_at(r + 3, 1'b0, 8, 1'b0, 1'b0, "resume_tick");

        // expiry: one-cycle Expire, Buzz for 8 cycles
        expect_at(r + 33, 1'b0, 1, 1'b0, 1'b0, "expire_pre");
        expect_at(r + 34, 1'b0, 1, 1'b1, 1'b1, "expire_edge");
        for (int i = 35; i <= 41; i++) expect_at(r + i, 1'b0, 0, 1'b0, 1'b1, "buzz_high");
        expect_at(r + 42, 1'b0, 0, 1'b0, 1'b0, "buzz_end");
        wait_until(r + 36);
        pulse(6'b000001, l);
        expect_at(r + 45, 1'b0, 0, 1'b0, 1'b0, "sp_ignored");
        wait_until(r + 46);
        pulse(6'b000010, l);
        expect_at(l + 1, 1'b0, 24, 1'b0, 1'b0, "reload");
        expect_at(l + 10, 1'b0, 24, 1'b0, 1'b0, "reload_idle");
        wait_until(l + 10);

        // Reload and ReloadAlt together in RUN at 05
        pulse(6'b000001, s);
        expect_at(s + 77, 1'b0, 5, 1'b0, 1'b0, "at_05");
        wait_until(s + 77);
        pulse(6'b000110, t);
        expect_at(t + 1, 1'b0, 24, 1'b0, 1'b0, "dual_reload");
        expect_at(t + 4, 1'b0, 24, 1'b0, 1'b0, "dual_hold");
        expect_at(t + 5, 1'b0, 23, 1'b0, 1'b0, "still_run");
        wait_until(t + 5);
        pulse(6'b000100, u);
        expect_at(u + 1, 1'b0, 14, 1'b0, 1'b0, "alt_load");
        expect_at(u + 5, 1'b0, 13, 1'b0, 1'b0, "alt_tick");
        wait_until(u + 6);

        // asynchronous reset between clock edges
        Reset = 1'b1;
        v = cyc;
        expect_at(v, 1'b0, 24, 1'b0, 1'b0, "async_reset");
        expect_at(v, 1'b1, 24, 1'b0, 1'b0, "b_async_rst");
        step();
        Reset = 1'b0;
        expect_at(v + 5, 1'b0, 24, 1'b0, 1'b0, "reset_idle");
        wait_until(v + 5);

        // auto-restart on dut_b
        pulse(6'b001000, q);
        expect_at(q + 4, 1'b1, 24, 1'b0, 1'b0, "b_pre_tick");
        expect_at(q + 5, 1'b1, 23, 1'b0, 1'b0, "b_first");
        expect_at(q + 95, 1'b1, 1, 1'b0, 1'b0, "b_pre_exp");
        expect_at(q + 96, 1'b1, 1, 1'b1, 1'b1, "b_expire");
        expect_at(q + 97, 1'b1, 0, 1'b0, 1'b1, "b_buzz");
        expect_at(q + 103, 1'b1, 0, 1'b0, 1'b1, "b_buzz_last");
        expect_at(q + 104, 1'b1, 0, 1'b0, 1'b0, "b_buzz_end");
        expect_at(q + 105, 1'b1, 24, 1'b0, 1'b0, "b_restart");
        expect_at(q + 108, 1'b1, 24, 1'b0, 1'b0, "b_hold");
        expect_at(q + 109, 1'b1, 23, 1'b0, 1'b0, "b_run_again");
        wait_until(q + 111);

        finishing = 1'b1;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
